// File: rtl/fpu_pkg.sv
// Shared types and widths for the fpu front-end sequencer.
// A word is {sign, exp, mant}.
package fpu_pkg;

  localparam int FP_W     = 32;
  localparam int EXP_W    = 7;
  localparam int MANT_W   = 24;
  localparam int STATUS_W = 4;
  localparam int PAIR_W   = 2 * FP_W;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    HOLD
  } seq_state_t;

  function automatic logic [PAIR_W-1:0] pack_pair(input fp_t a, input fp_t b);
    return {a, b};
  endfunction

endpackage

// File: rtl/fpu_op_sequencer_if.sv
// Operand stream, fpu launch/capture and result stream of the sequencer.
// slave is the sequencer side; master is the surrounding system (producer, fpu, consumer).
interface fpu_op_sequencer_if;
  import fpu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  fp_t                 in_op_a;
  fp_t                 in_op_b;
  logic                fpu_start;
  fp_t                 fpu_op_a;
  fp_t                 fpu_op_b;
  fp_t                 fpu_data;
  logic [STATUS_W-1:0] fpu_status;
  logic                res_valid;
  logic                res_ready;
  fp_t                 res_data;
  logic [STATUS_W-1:0] res_status;
  logic                busy;

  modport slave (
    input  in_valid, in_op_a, in_op_b, fpu_data, fpu_status, res_ready,
    output in_ready, fpu_start, fpu_op_a, fpu_op_b, res_valid, res_data, res_status, busy
  );

  modport master (
    output in_valid, in_op_a, in_op_b, fpu_data, fpu_status, res_ready,
    input  in_ready, fpu_start, fpu_op_a, fpu_op_b, res_valid, res_data, res_status, busy
  );

endinterface

// File: rtl/fpu_operand_fifo.sv
// Operand-pair FIFO with show-ahead read data; DEPTH must be a power of two
// so the pointers wrap on their own.
module fpu_operand_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Front-end sequencer for the fpu adder: buffers operand pairs, launches one
// operation at a time, waits a fixed latency and holds the result for handoff.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int FPU_LATENCY = 64
) (
  input logic               clock,
  input logic               reset,
  fpu_op_sequencer_if.slave io
);

  localparam int CNT_W = $clog2(FPU_LATENCY + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  seq_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [PAIR_W-1:0]   head;
  logic                full;
  logic                empty;
  logic [CW-1:0]       count;
  logic                pop;

  logic                start_p0;
  fp_t                 op_a_p0;
  fp_t                 op_b_p0;
  logic                vld_p1;
  fp_t                 res_data_p1;
  logic [STATUS_W-1:0] res_status_p1;

  assign pop = (state == IDLE) && !empty;

  fpu_operand_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (io.in_valid),
    .wr_data (pack_pair(io.in_op_a, io.in_op_b)),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      start_p0      <= 1'b0;
      op_a_p0       <= '0;
      op_b_p0       <= '0;
      vld_p1        <= 1'b0;
      res_data_p1   <= '0;
      res_status_p1 <= '0;
    end else begin
      start_p0 <= 1'b0;
      unique case (state)
        // launch: operands stay on the fpu inputs until the next launch
        IDLE: begin
          if (pop) begin
            op_a_p0  <= fp_t'(head[PAIR_W-1:FP_W]);
            op_b_p0  <= fp_t'(head[FP_W-1:0]);
            start_p0 <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt   <= CNT_W'(FPU_LATENCY - 1);
          state <= WAIT;
        end
        // capture: fpu outputs are stable once the counter has run out
        WAIT: begin
          if (cnt == '0) begin
            res_data_p1   <= io.fpu_data;
            res_status_p1 <= io.fpu_status;
            vld_p1        <= 1'b1;
            state         <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (io.res_ready) begin
            vld_p1 <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.in_ready   = !full;
  assign io.fpu_start  = start_p0;
  assign io.fpu_op_a   = op_a_p0;
  assign io.fpu_op_b   = op_b_p0;
  assign io.res_valid  = vld_p1;
  assign io.res_data   = res_data_p1;
  assign io.res_status = res_status_p1;
  assign io.busy       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboarded bench for fpu_op_sequencer with a stub fpu returning A^B.
module tb_fpu_op_sequencer;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fpu_op_sequencer_if sif ();

  fpu_op_sequencer #(
    .FIFO_DEPTH  (DEPTH),
    .FPU_LATENCY (LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (sif)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stub fpu: garbage until FPU_LATENCY cycles after start, then A^B / 1010
  logic [31:0] stub_res;
  int          stub_k;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      stub_k         <= 0;
      stub_res       <= '0;
      sif.fpu_data   <= '0;
      sif.fpu_status <= '0;
    end else if (sif.fpu_start) begin
      stub_res       <= sif.fpu_op_a ^ sif.fpu_op_b;
      stub_k         <= 1;
      sif.fpu_data   <= $urandom;
      sif.fpu_status <= 4'($urandom);
    end else if (stub_k > 0) begin
      if (stub_k == LAT - 1) begin
        sif.fpu_data   <= stub_res;
        sif.fpu_status <= 4'b1010;
        stub_k         <= 0;
      end else begin
        stub_k <= stub_k + 1;
      end
    end
  end

  // Reference model: pairs awaiting launch, results awaiting handoff
  logic [63:0] launch_q[$];
  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];
  logic [63:0] lp;
  logic [35:0] ep;
  int outstanding = 0;
  int last_start  = -1000;
  int exp_start   = -1;
  int last_hs     = -1;
  int last_acc    = -1;
  int n_accepted  = 0;
  logic prev_rv   = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      launch_q.delete();
      exp_q.delete();
      outstanding = 0;
      exp_start   = -1;
      prev_rv     = 1'b0;
    end else begin
      if (sif.in_valid && sif.in_ready) begin
        if (outstanding == 0 && launch_q.size() == 0 && exp_start < 0) exp_start = cyc + 2;
        launch_q.push_back({sif.in_op_a, sif.in_op_b});
        exp_q.push_back({sif.in_op_a ^ sif.in_op_b, 4'b1010});
        n_accepted++;
        last_acc = cyc;
      end
      if (sif.fpu_start) begin
        chk("one_in_flight", 64'(outstanding), 64'(0));
        chk("start_cycle", 64'(cyc), 64'(exp_start));
        exp_start = -1;
        if (launch_q.size() == 0) begin
          chk("start_without_pair", 64'(1), 64'(0));
        end else begin
          lp = launch_q.pop_front();
          chk("fpu_op_a", 64'(sif.fpu_op_a), 64'(lp[63:32]));
          chk("fpu_op_b", 64'(sif.fpu_op_b), 64'(lp[31:0]));
        end
        outstanding = 1;
        last_start  = cyc;
      end
      if (sif.res_valid && !prev_rv) begin
        chk("res_valid_with_op", 64'(outstanding), 64'(1));
        chk("res_valid_cycle", 64'(cyc), 64'(last_start + LAT + 1));
      end
      prev_rv = sif.res_valid;
      if (sif.res_valid && sif.res_ready) begin
        if (exp_q.size() == 0) begin
          chk("result_without_push", 64'(1), 64'(0));
        end else begin
          ep = exp_q.pop_front();
          chk("res_data", 64'(sif.res_data), 64'(ep[35:4]));
          chk("res_status", 64'(sif.res_status), 64'(ep[3:0]));
        end
        got_q.push_back({sif.res_data, sif.res_status});
        outstanding = 0;
        last_hs     = cyc;
        if (launch_q.size() > 0) exp_start = cyc + 2;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input int maxc);
    bit ok = 1'b0;
    sif.in_valid = 1'b1;
    sif.in_op_a  = a;
    sif.in_op_b  = b;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clock);
      if (sif.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    sif.in_valid = 1'b0;
    if (!ok) chk("push_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_got(input int n, input int maxc);
    for (int i = 0; i < maxc && got_q.size() < n; i++) @(negedge clock);
    chk("results_arrived", 64'(got_q.size()), 64'(n));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] hold_d;
  logic [3:0]  hold_s;
  int          acc_before;
  bit          quiet_bad;
  bit          done;
  logic [31:0] a6 [3];
  logic [31:0] b6 [3];
  logic [31:0] r6 [3];

  initial begin
    sif.in_valid  = 1'b0;
    sif.in_op_a   = '0;
    sif.in_op_b   = '0;
    sif.res_ready = 1'b0;

    // 1. reset
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ctrl", 64'({sif.fpu_start, sif.res_valid, sif.busy}), 64'(0));
    chk("rst_fpu_ops", {sif.fpu_op_a, sif.fpu_op_b}, 64'(0));
    chk("rst_res", 64'({sif.res_data, sif.res_status}), 64'(0));
    chk("rst_in_ready", 64'(sif.in_ready), 64'(1));
    reset = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", 64'(sif.in_ready), 64'(1));
    chk("post_rst_busy", 64'(sif.busy), 64'(0));
    step();

    // 2. single operation
    sif.res_ready = 1'b1;
    got_q.delete();
    push(32'h4080_0000, 32'h3FC0_0000, 10);
    wait_got(1, LAT + 20);
    if (got_q.size() > 0) chk("single_result", 64'(got_q[0]), 64'({32'h7F40_0000, 4'b1010}));
    repeat (5) step();

    // 3 + 4. fill the FIFO while the result is held
    sif.res_ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 5; i++) push($urandom, $urandom, 3);
    @(negedge clock);
    chk("in_ready_full", 64'(sif.in_ready), 64'(0));
    step();
    fork
      push(32'h1234_5678, 32'h0F0F_0F0F, 3 * LAT + 60);
    join_none
    for (int i = 0; i < LAT + 10 && !sif.res_valid; i++) @(negedge clock);
    chk("first_res_valid", 64'(sif.res_valid), 64'(1));
    hold_d     = sif.res_data;
    hold_s     = sif.res_status;
    acc_before = n_accepted;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("hold_data", 64'(sif.res_data), 64'(hold_d));
      chk("hold_status", 64'(sif.res_status), 64'(hold_s));
      chk("hold_no_start", 64'(sif.fpu_start), 64'(0));
      chk("hold_busy", 64'(sif.busy), 64'(1));
    end
    chk("sixth_held", 64'(n_accepted), 64'(acc_before));
    step();
    sif.res_ready = 1'b1;
    wait fork;
    chk("sixth_after_hs", 64'(last_acc > last_hs), 64'(1));
    wait_got(6, 8 * (LAT + 10));
    repeat (5) step();

    // 5. reset during WAIT with two pairs queued
    for (int i = 0; i < 3; i++) push($urandom, $urandom, 3);
    repeat (LAT / 2) step();
    chk("pre_reset_busy", 64'(sif.busy), 64'(1));
    reset = 1'b0;
    @(negedge clock);
    chk("mid_rst_res_valid", 64'(sif.res_valid), 64'(0));
    chk("mid_rst_busy", 64'(sif.busy), 64'(0));
    chk("mid_rst_in_ready", 64'(sif.in_ready), 64'(1));
    @(negedge clock);
    reset = 1'b1;
    quiet_bad = 1'b0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clock);
      if (sif.fpu_start || sif.res_valid) quiet_bad = 1'b1;
    end
    chk("post_reset_quiet", 64'(quiet_bad), 64'(0));
    chk("post_reset_busy", 64'(sif.busy), 64'(0));
    step();

    // 6. directed values in order
    a6 = '{32'h3F40_0000, 32'h0000_0000, 32'hC140_0000};
    b6 = '{32'hBF40_0000, 32'h0000_0000, 32'h4140_0000};
    r6 = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000};
    got_q.delete();
    for (int i = 0; i < 3; i++) push(a6[i], b6[i], 3 * LAT);
    wait_got(3, 4 * (LAT + 10));
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      chk("dir_data", 64'(got_q[i][35:4]), 64'(r6[i]));
      chk("dir_status", 64'(got_q[i][3:0]), 64'(4'b1010));
    end
    repeat (3) step();

    // 7. random traffic with random backpressure
    got_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 3)) step();
          push($urandom, $urandom, 6 * (LAT + 10));
        end
      end
      begin
        while (!done) begin
          step();
          sif.res_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        wait_got(40, 40 * 2 * (LAT + 12));
        done = 1'b1;
      end
    join
    sif.res_ready = 1'b1;
    repeat (5) step();
    chk("final_idle", 64'(sif.busy), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
